// File: rtl/register_file_mp.sv
// Multi-port register file: two synchronous read ports, two write ports, optional hardwired zero entry and write-to-read bypass.
// Latency: one cycle for reads and writes; there is no backpressure, so every port can issue on every cycle.
module register_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rnum1,
    input  logic                  ren1,
    input  logic [ADDR_WIDTH-1:0] rnum2,
    input  logic                  ren2,
    input  logic [ADDR_WIDTH-1:0] wnum_a,
    input  logic                  write_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic [ADDR_WIDTH-1:0] wnum_b,
    input  logic                  write_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    output logic                  wconflict
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DATA_WIDTH-1:0] rd_next1;
    logic [DATA_WIDTH-1:0] rd_next2;
    logic                  conflict;

    assign conflict = write_a && write_b && (wnum_a == wnum_b);

    // Port B is checked first in each entry so it wins a same-index collision.
    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_entry
            localparam logic [ADDR_WIDTH-1:0] IDX = ADDR_WIDTH'(i);
            if (ZERO_REG != 0 && i == 0) begin : g_zero
                assign regs[i] = '0;
            end else begin : g_reg
                logic [DATA_WIDTH-1:0] q;
                always_ff @(posedge clock or posedge reset) begin
                    if (reset) begin
                        q <= '0;
                    end else if (write_b && (wnum_b == IDX)) begin
                        q <= wdata_b;
                    end else if (write_a && (wnum_a == IDX)) begin
                        q <= wdata_a;
                    end
                end
                assign regs[i] = q;
            end
        end
    endgenerate

    always_comb begin
        rd_next1 = regs[rnum1];
        if (BYPASS != 0) begin
            if (write_b && (wnum_b == rnum1)) begin
                rd_next1 = wdata_b;
            end else if (write_a && (wnum_a == rnum1)) begin
                rd_next1 = wdata_a;
            end
        end
        // Zero entry overrides bypass: a write to it never becomes visible.
        if (ZERO_REG != 0 && rnum1 == '0) begin
            rd_next1 = '0;
        end
    end

    always_comb begin
        rd_next2 = regs[rnum2];
        if (BYPASS != 0) begin
            if (write_b && (wnum_b == rnum2)) begin
                rd_next2 = wdata_b;
            end else if (write_a && (wnum_a == rnum2)) begin
                rd_next2 = wdata_a;
            end
        end
        if (ZERO_REG != 0 && rnum2 == '0) begin
            rd_next2 = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata1    <= '0;
            rdata2    <= '0;
            wconflict <= 1'b0;
        end else begin
            if (ren1) begin
                rdata1 <= rd_next1;
            end
            if (ren2) begin
                rdata2 <= rd_next2;
            end
            wconflict <= conflict;
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: default instance, a no-zero/no-bypass twin sharing its inputs, and a 16x8 instance.
module tb_register_file_mp;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic [4:0]  rnum1, rnum2, wnum_a, wnum_b;
    logic        ren1, ren2, write_a, write_b;
    logic [31:0] wdata_a, wdata_b;
    logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic        a_wc, b_wc;

    logic [2:0]  s_rnum1, s_rnum2, s_wnum_a, s_wnum_b;
    logic        s_ren1, s_ren2, s_write_a, s_write_b;
    logic [15:0] s_wdata_a, s_wdata_b, s_rd1, s_rd2;
    logic        s_wc;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    register_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clock(clock), .reset(reset),
        .rnum1(rnum1), .ren1(ren1), .rnum2(rnum2), .ren2(ren2),
        .wnum_a(wnum_a), .write_a(write_a), .wdata_a(wdata_a),
        .wnum_b(wnum_b), .write_b(write_b), .wdata_b(wdata_b),
        .rdata1(a_rd1), .rdata2(a_rd2), .wconflict(a_wc));

    register_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clock(clock), .reset(reset),
        .rnum1(rnum1), .ren1(ren1), .rnum2(rnum2), .ren2(ren2),
        .wnum_a(wnum_a), .write_a(write_a), .wdata_a(wdata_a),
        .wnum_b(wnum_b), .write_b(write_b), .wdata_b(wdata_b),
        .rdata1(b_rd1), .rdata2(b_rd2), .wconflict(b_wc));

    register_file_mp #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(0), .BYPASS(1)) dut_s (
        .clock(clock), .reset(reset),
        .rnum1(s_rnum1), .ren1(s_ren1), .rnum2(s_rnum2), .ren2(s_ren2),
        .wnum_a(s_wnum_a), .write_a(s_write_a), .wdata_a(s_wdata_a),
        .wnum_b(s_wnum_b), .write_b(s_write_b), .wdata_b(s_wdata_b),
        .rdata1(s_rd1), .rdata2(s_rd2), .wconflict(s_wc));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        ren1 = 0; ren2 = 0; write_a = 0; write_b = 0;
        rnum1 = 0; rnum2 = 0; wnum_a = 0; wnum_b = 0;
        wdata_a = 0; wdata_b = 0;
        s_ren1 = 0; s_ren2 = 0; s_write_a = 0; s_write_b = 0;
        s_rnum1 = 0; s_rnum2 = 0; s_wnum_a = 0; s_wnum_b = 0;
        s_wdata_a = 0; s_wdata_b = 0;
    endtask

    task automatic test_reset();
        #3;
        n_vec++;
        if (a_rd1 !== 32'h0 || a_rd2 !== 32'h0 || a_wc !== 1'b0 || s_rd1 !== 16'h0 || s_wc !== 1'b0) begin
            n_err++;
            $display("FAIL reset_init: a_rd1=%h a_rd2=%h a_wc=%b s_rd1=%h s_wc=%b, need all zero", a_rd1, a_rd2, a_wc, s_rd1, s_wc);
        end
        @(posedge clock);
        #2 reset = 0;
        // Load a value, read it back, then reset in the middle of the cycle.
        wnum_a = 5; wdata_a = 32'hDEADBEEF; write_a = 1;
        tick();
        idle();
        rnum1 = 5; rnum2 = 5; ren1 = 1; ren2 = 1;
        tick();
        n_vec++;
        if (a_rd1 !== 32'hDEADBEEF || a_rd2 !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL reset_preload: rd1=%h rd2=%h, need deadbeef", a_rd1, a_rd2);
        end
        #2 reset = 1;
        #1;
        n_vec++;
        if (a_rd1 !== 32'h0 || a_rd2 !== 32'h0 || b_rd1 !== 32'h0 || b_rd2 !== 32'h0) begin
            n_err++;
            $display("FAIL reset_async: a=%h/%h b=%h/%h, need 0", a_rd1, a_rd2, b_rd1, b_rd2);
        end
        // A write presented across an edge while reset is held must be discarded.
        idle();
        wnum_a = 6; wdata_a = 32'hCAFEF00D; write_a = 1;
        tick();
        #2 reset = 0;
        idle();
        rnum1 = 5; rnum2 = 6; ren1 = 1; ren2 = 1;
        tick();
        n_vec++;
        if (a_rd1 !== 32'h0 || b_rd1 !== 32'h0) begin
            n_err++;
            $display("FAIL reset_clears_idx5: a=%h b=%h, need 0", a_rd1, b_rd1);
        end
        n_vec++;
        if (a_rd2 !== 32'h0 || b_rd2 !== 32'h0) begin
            n_err++;
            $display("FAIL reset_drops_write: a=%h b=%h, need 0", a_rd2, b_rd2);
        end
        idle();
    endtask

    task automatic test_read_hold();
        wnum_a = 3; wdata_a = 32'h11111111; write_a = 1;
        tick();
        idle();
        rnum1 = 3; ren1 = 1;
        tick();
        n_vec++;
        if (a_rd1 !== 32'h11111111 || b_rd1 !== 32'h11111111) begin
            n_err++;
            $display("FAIL read_latency: a=%h b=%h, need 11111111", a_rd1, b_rd1);
        end
        rnum1 = 4; ren1 = 0;
        tick();
        n_vec++;
        if (a_rd1 !== 32'h11111111 || b_rd1 !== 32'h11111111) begin
            n_err++;
            $display("FAIL read_hold: a=%h b=%h, need 11111111", a_rd1, b_rd1);
        end
        rnum1 = 3; rnum2 = 3; ren1 = 1; ren2 = 1;
        tick();
        n_vec++;
        if (a_rd2 !== 32'h11111111 || a_rd1 !== a_rd2 || b_rd2 !== 32'h11111111) begin
            n_err++;
            $display("FAIL dual_read_same: a=%h/%h b=%h, need 11111111", a_rd1, a_rd2, b_rd2);
        end
        idle();
    endtask

    task automatic test_conflict();
        wnum_a = 7; wdata_a = 32'hAAAA0000; write_a = 1;
        wnum_b = 7; wdata_b = 32'h0000BBBB; write_b = 1;
        tick();
        idle();
        n_vec++;
        if (a_wc !== 1'b1 || b_wc !== 1'b1) begin
            n_err++;
            $display("FAIL conflict_set: a=%b b=%b, need 1", a_wc, b_wc);
        end
        rnum1 = 7; ren1 = 1;
        tick();
        n_vec++;
        if (a_wc !== 1'b0 || b_wc !== 1'b0) begin
            n_err++;
            $display("FAIL conflict_one_cycle: a=%b b=%b, need 0", a_wc, b_wc);
        end
        n_vec++;
        if (a_rd1 !== 32'h0000BBBB || b_rd1 !== 32'h0000BBBB) begin
            n_err++;
            $display("FAIL conflict_b_wins: a=%h b=%h, need 0000bbbb", a_rd1, b_rd1);
        end
        idle();
        wnum_a = 10; wdata_a = 32'h0A0A0A0A; write_a = 1;
        wnum_b = 11; wdata_b = 32'h0B0B0B0B; write_b = 1;
        tick();
        idle();
        n_vec++;
        if (a_wc !== 1'b0) begin
            n_err++;
            $display("FAIL conflict_distinct: a=%b, need 0", a_wc);
        end
        rnum1 = 10; rnum2 = 11; ren1 = 1; ren2 = 1;
        tick();
        n_vec++;
        if (a_rd1 !== 32'h0A0A0A0A || a_rd2 !== 32'h0B0B0B0B) begin
            n_err++;
            $display("FAIL dual_write_distinct: rd1=%h rd2=%h, need 0a0a0a0a/0b0b0b0b", a_rd1, a_rd2);
        end
        idle();
    endtask

    task automatic test_bypass();
        wnum_b = 9; wdata_b = 32'h12345678; write_b = 1;
        rnum2 = 9; ren2 = 1;
        tick();
        idle();
        n_vec++;
        if (a_rd2 !== 32'h12345678) begin
            n_err++;
            $display("FAIL bypass_on: got %h, need 12345678", a_rd2);
        end
        n_vec++;
        if (b_rd2 !== 32'h0) begin
            n_err++;
            $display("FAIL bypass_off: got %h, need 00000000", b_rd2);
        end
        rnum2 = 9; ren2 = 1;
        tick();
        n_vec++;
        if (b_rd2 !== 32'h12345678 || a_rd2 !== 32'h12345678) begin
            n_err++;
            $display("FAIL bypass_off_next: a=%h b=%h, need 12345678", a_rd2, b_rd2);
        end
        // Both write ports hit the read index: bypass must forward port B.
        idle();
        wnum_a = 12; wdata_a = 32'h00000001; write_a = 1;
        wnum_b = 12; wdata_b = 32'h00000002; write_b = 1;
        rnum1 = 12; ren1 = 1;
        tick();
        idle();
        n_vec++;
        if (a_rd1 !== 32'h00000002 || b_rd1 !== 32'h0) begin
            n_err++;
            $display("FAIL bypass_both_ports: a=%h b=%h, need 00000002/00000000", a_rd1, b_rd1);
        end
        wnum_a = 13; wdata_a = 32'h13131313; write_a = 1;
        rnum1 = 13; ren1 = 1;
        tick();
        idle();
        n_vec++;
        if (a_rd1 !== 32'h13131313 || b_rd1 !== 32'h0) begin
            n_err++;
            $display("FAIL bypass_port_a: a=%h b=%h, need 13131313/00000000", a_rd1, b_rd1);
        end
    endtask

    task automatic test_zero_reg();
        wnum_a = 0; wdata_a = 32'hFFFFFFFF; write_a = 1;
        rnum1 = 0; ren1 = 1;
        tick();
        idle();
        n_vec++;
        if (a_rd1 !== 32'h0 || b_rd1 !== 32'h0) begin
            n_err++;
            $display("FAIL zero_same_cycle: a=%h b=%h, need 0", a_rd1, b_rd1);
        end
        rnum1 = 0; ren1 = 1;
        tick();
        n_vec++;
        if (a_rd1 !== 32'h0) begin
            n_err++;
            $display("FAIL zero_readback: got %h, need 00000000", a_rd1);
        end
        n_vec++;
        if (b_rd1 !== 32'hFFFFFFFF) begin
            n_err++;
            $display("FAIL nozero_readback: got %h, need ffffffff", b_rd1);
        end
        idle();
        wnum_a = 0; wdata_a = 32'h55555555; write_a = 1;
        wnum_b = 0; wdata_b = 32'h66666666; write_b = 1;
        rnum2 = 0; ren2 = 1;
        tick();
        idle();
        n_vec++;
        if (a_wc !== 1'b1 || a_rd2 !== 32'h0) begin
            n_err++;
            $display("FAIL zero_conflict: wc=%b rd2=%h, need 1/00000000", a_wc, a_rd2);
        end
    endtask

    task automatic test_sweep();
        for (int k = 0; k < 8; k += 2) begin
            s_wnum_a = 3'(k);     s_wdata_a = 16'(k * 16'h1111);       s_write_a = 1;
            s_wnum_b = 3'(k + 1); s_wdata_b = 16'((k + 1) * 16'h1111); s_write_b = 1;
            tick();
        end
        s_write_a = 0; s_write_b = 0;
        for (int k = 0; k < 8; k++) begin
            s_rnum1 = 3'(k); s_rnum2 = 3'(7 - k); s_ren1 = 1; s_ren2 = 1;
            tick();
            n_vec++;
            if (s_rd1 !== 16'(k * 16'h1111) || s_rd2 !== 16'((7 - k) * 16'h1111)) begin
                n_err++;
                $display("FAIL sweep_idx%0d: rd1=%h rd2=%h, need %h/%h", k, s_rd1, s_rd2,
                         16'(k * 16'h1111), 16'((7 - k) * 16'h1111));
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_read_hold();
        test_conflict();
        test_bypass();
        test_zero_reg();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
